// File: rtl/jt12_mix.sv
// jt12_mix: NCH-channel mixer with a Q4.4 gain per channel, one shared MAC and a saturating output.
// Latency: in_sample taken on cen cycle k gives snd/snd_sample after the edge of cen cycle k+NCH+1.
// Backpressure: none; in_sample while busy is dropped and sets drop. JT12_MIX_READBACK_EN enables dout readback.
module jt12_mix #(
    parameter int NCH  = 4,
    parameter int W    = 16,
    parameter int OUTW = 16,
    parameter int GW   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cen,
    input  logic [7:0]           din,
    input  logic [3:0]           addr,
    input  logic                 cs_n,
    input  logic                 wr_n,
    output logic [7:0]           dout,
    input  logic [NCH*W-1:0]     ch_in,
    input  logic                 in_sample,
    output logic [OUTW-1:0]      snd,
    output logic                 snd_sample,
    output logic                 busy
);

    // Accumulator is wide enough for NCH <= 8 full-scale products, so it never wraps.
    localparam int AW = W + GW + 3;
    localparam int IW = $clog2(NCH);
    localparam logic [GW-1:0] UNITY = GW'(16);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NCH*W-1:0]       snap_q;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [IW-1:0]          idx_q;
    logic                   busy_q;
    logic [OUTW-1:0]        snd_q;
    logic                   snd_sample_q;
    logic [GW-1:0]          gain_q [NCH];
    logic                   mute_q, ovf_q, drop_q;

    logic                   bus_wr, ctrl_wr;
    logic                   out_fire, ovf_set, drop_set, ovf_clr, drop_clr;
    logic signed [W-1:0]    cur_smp;
    logic [GW-1:0]          cur_gain;
    logic signed [W+GW:0]   prod;
    logic signed [AW-1:0]   r_sh;
    logic [AW-OUTW:0]       r_hi;
    logic                   clip;
    logic [OUTW-1:0]        sat_r;

    assign bus_wr   = !cs_n && !wr_n;
    assign ctrl_wr  = bus_wr && (addr == 4'hF);
    assign out_fire = cen && (state_q == ST_OUT);
    assign drop_set = cen && in_sample && (state_q != ST_IDLE);
    assign ovf_set  = out_fire && clip;
    assign ovf_clr  = ctrl_wr && din[1];
    assign drop_clr = ctrl_wr && din[2];

    // MAC operand selection: signed sample times zero-extended (unsigned) gain.
    assign cur_smp  = snap_q[idx_q*W +: W];
    assign cur_gain = gain_q[idx_q];
    assign prod     = cur_smp * $signed({1'b0, cur_gain});
    assign acc_d    = acc_q + {{(AW-W-GW-1){prod[W+GW]}}, prod};

    // Remove the Q4.4 fraction (floor), then clip when the upper bits are not a pure sign extension.
    assign r_sh  = acc_q >>> 4;
    assign r_hi  = r_sh[AW-1:OUTW-1];
    assign clip  = !((&r_hi) || !(|r_hi));
    assign sat_r = !clip      ? r_sh[OUTW-1:0] :
                   r_sh[AW-1] ? {1'b1, {(OUTW-1){1'b0}}} :
                                {1'b0, {(OUTW-1){1'b1}}};

    // Next-state logic of the IDLE -> ACC -> OUT sequencer; it only moves on cen cycles.
    always_comb begin
        state_d = state_q;
        if (cen) begin
            case (state_q)
                ST_IDLE: if (in_sample) state_d = ST_ACC;
                ST_ACC:  if (idx_q == IW'(NCH-1)) state_d = ST_OUT;
                ST_OUT:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Datapath: snapshot on accept, one MAC per cen cycle, registered saturated output and strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q       <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            snd_q        <= '0;
            snd_sample_q <= 1'b0;
        end else begin
            snd_sample_q <= out_fire;
            if (cen) begin
                case (state_q)
                    ST_IDLE: begin
                        if (in_sample) begin
                            snap_q <= ch_in;
                            acc_q  <= '0;
                            idx_q  <= '0;
                            busy_q <= 1'b1;
                        end
                    end
                    ST_ACC: begin
                        acc_q <= acc_d;
                        idx_q <= idx_q + 1'b1;
                    end
                    ST_OUT: begin
                        snd_q  <= mute_q ? '0 : sat_r;
                        busy_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Bus-writable gains and control; sticky flags win over a same-edge clear so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) gain_q[i] <= UNITY;
            mute_q <= 1'b0;
            ovf_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            if (bus_wr) begin
                for (int i = 0; i < NCH; i++) begin
                    if (addr == 4'(i)) gain_q[i] <= GW'(din);
                end
            end
            if (ctrl_wr) mute_q <= din[0];
            ovf_q  <= (ovf_q  & ~ovf_clr)  | ovf_set;
            drop_q <= (drop_q & ~drop_clr) | drop_set;
        end
    end

`ifdef JT12_MIX_READBACK_EN
    logic [7:0] rd_dat;
    logic [7:0] dout_q;

    // Read mux: gain registers, control/status, zero elsewhere.
    always_comb begin
        rd_dat = 8'd0;
        for (int i = 0; i < NCH; i++) begin
            if (addr == 4'(i)) rd_dat = 8'(gain_q[i]);
        end
        if (addr == 4'hF) rd_dat = {5'd0, drop_q, ovf_q, mute_q};
    end

    // Registered read data, updated only on read cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             dout_q <= 8'd0;
        else if (!cs_n && wr_n) dout_q <= rd_dat;
    end

    assign dout = dout_q;
`else
    assign dout = 8'd0;
`endif

    assign snd        = snd_q;
    assign snd_sample = snd_sample_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_jt12_mix.sv
// tb_jt12_mix: directed and randomized checks of jt12_mix against a behavioural model.
// The model works in plain integer arithmetic on the mixing rules; a negedge process compares every cycle.
// Directed cases pin the model with hand-computed literals.
module tb_jt12_mix;

    localparam int NCH  = 4;
    localparam int W    = 16;
    localparam int OUTW = 16;
    localparam int GW   = 8;
    localparam longint SMAX = 32767;
    localparam longint SMIN = -32768;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               cen = 1'b1;
    logic [7:0]         din = 8'd0;
    logic [3:0]         addr = 4'd0;
    logic               cs_n = 1'b1;
    logic               wr_n = 1'b1;
    logic [7:0]         dout;
    logic [NCH*W-1:0]   ch_in = '0;
    logic               in_sample = 1'b0;
    logic [OUTW-1:0]    snd;
    logic               snd_sample;
    logic               busy;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int cen_mode = 0;
    int cyc = 0;

    jt12_mix #(.NCH(NCH), .W(W), .OUTW(OUTW), .GW(GW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .din        (din),
        .addr       (addr),
        .cs_n       (cs_n),
        .wr_n       (wr_n),
        .dout       (dout),
        .ch_in      (ch_in),
        .in_sample  (in_sample),
        .snd        (snd),
        .snd_sample (snd_sample),
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic signed [W-1:0] m_snap [NCH];
    int     m_gain [NCH];
    bit     m_mute, m_ovf, m_drop, m_pulse;
    int     m_left = 0;      // cen cycles still to go before the result appears
    longint m_acc, m_snd = 0;
    int     m_dout = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) m_gain[i] = 16;
            m_mute = 0; m_ovf = 0; m_drop = 0; m_pulse = 0;
            m_left = 0; m_acc = 0; m_snd = 0; m_dout = 0;
        end else begin
            bit set_ovf, set_drop;
            set_ovf = 0; set_drop = 0;
            m_pulse = 0;
            if (!cs_n && wr_n) begin
                if (addr < NCH)       m_dout = m_gain[addr];
                else if (addr == 15)  m_dout = 4 * int'(m_drop) + 2 * int'(m_ovf) + int'(m_mute);
                else                  m_dout = 0;
            end
            if (cen) begin
                if (m_left > 0) begin
                    int j;
                    if (in_sample) set_drop = 1;
                    j = NCH + 1 - m_left;   // which channel this cen cycle weights, NCH = output cycle
                    if (j < NCH) begin
                        m_acc += longint'(m_snap[j]) * longint'(m_gain[j]);
                    end else begin
                        longint r;
                        r = m_acc >>> 4;
                        if (r > SMAX) begin r = SMAX; set_ovf = 1; end
                        if (r < SMIN) begin r = SMIN; set_ovf = 1; end
                        m_snd = m_mute ? 0 : r;
                        m_pulse = 1;
                    end
                    m_left--;
                end else if (in_sample) begin
                    for (int i = 0; i < NCH; i++) m_snap[i] = ch_in[i*W +: W];
                    m_acc = 0;
                    m_left = NCH + 1;
                end
            end
            if (!cs_n && !wr_n) begin
                if (addr < NCH) m_gain[addr] = int'(din);
                if (addr == 15) begin
                    m_mute = din[0];
                    if (din[1]) m_ovf = 0;
                    if (din[2]) m_drop = 0;
                end
            end
            m_ovf  = m_ovf  | set_ovf;
            m_drop = m_drop | set_drop;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", longint'(busy), longint'(m_left > 0));
            check("snd_sample", longint'(snd_sample), longint'(m_pulse));
            check("snd", longint'($signed(snd)), m_snd);
`ifdef JT12_MIX_READBACK_EN
            check("dout", longint'(dout), longint'(m_dout));
`else
            check("dout", longint'(dout), 0);
`endif
        end
    end

    // cen generator: always-on, 1-of-3, or random.
    always @(posedge clk) begin
        #1;
        cyc++;
        case (cen_mode)
            0:       cen = 1'b1;
            1:       cen = (cyc % 3 == 0);
            default: cen = ($urandom % 4) != 0;
        endcase
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input int a, input int d);
        cs_n = 1'b0; wr_n = 1'b0; addr = 4'(a); din = 8'(d);
        tick();
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic rd(input int a, output int v);
        cs_n = 1'b0; wr_n = 1'b1; addr = 4'(a);
        tick();
        cs_n = 1'b1;
        v = int'(dout);
    endtask

    task automatic set_ch(input int v0, input int v1, input int v2, input int v3);
        ch_in = {W'(v3), W'(v2), W'(v1), W'(v0)};
    endtask

    // Hold in_sample until a cen edge has seen it.
    task automatic strobe();
        bit c;
        int g;
        g = 0;
        in_sample = 1'b1;
        do begin
            @(posedge clk); c = cen; #1; g++;
        end while (!c && g < 100);
        in_sample = 1'b0;
        check("strobe_cen_seen", longint'(c), 1);
    endtask

    // Clock count from the accept edge to the snd_sample pulse.
    task automatic wait_pulse(output int n);
        n = 0;
        while (!snd_sample && n < 200) begin
            tick();
            n++;
        end
        check("pulse_seen", longint'(snd_sample), 1);
    endtask

    initial begin
        int n, v, cnt;

        #3 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        check("rst_snd", longint'(snd), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_pulse", longint'(snd_sample), 0);
        check("rst_dout", longint'(dout), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Unity mix at reset gains: 1000 + 2000 - 500 + 0.
        set_ch(1000, 2000, -500, 0);
        strobe();
        check("unity_busy", longint'(busy), 1);
        wait_pulse(n);
        check("unity_latency", n, 5);
        check("unity_snd", longint'($signed(snd)), 2500);
        check("unity_model", m_snd, 2500);
        tick();
        check("pulse_one_clk", longint'(snd_sample), 0);

        // Half gain on a negative odd value floors: -3*8/16 = -1.5 -> -2.
        wr(0, 8'h08); wr(1, 0); wr(2, 0); wr(3, 0);
        set_ch(-3, 1234, -999, 77);
        strobe(); wait_pulse(n);
        check("floor_snd", longint'($signed(snd)), -2);
        check("floor_model", m_snd, -2);

        wr(0, 8'h20);
        set_ch(1000, 5, 6, 7);
        strobe(); wait_pulse(n);
        check("gain2_snd", longint'($signed(snd)), 2000);

        // Saturation both ways.
        for (int i = 0; i < NCH; i++) wr(i, 8'h20);
        set_ch(32767, 32767, 32767, 32767);
        strobe(); wait_pulse(n);
        check("satpos_snd", longint'(snd), 16'h7FFF);
`ifdef JT12_MIX_READBACK_EN
        rd(15, v); check("ovf_set", v, 2);
        wr(15, 2);
        rd(15, v); check("ovf_clear", v, 0);
`endif
        set_ch(-32768, -32768, -32768, -32768);
        strobe(); wait_pulse(n);
        check("satneg_snd", longint'(snd), 16'h8000);
        wr(15, 2);

        // Collision: second strobe two cycles after the first is dropped.
        for (int i = 0; i < NCH; i++) wr(i, 8'h10);
        set_ch(10, 20, 30, 40);
        strobe(); tick();
        set_ch(999, 999, 999, 999);
        strobe();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (snd_sample) cnt++;
        end
        check("collide_pulses", cnt, 1);
        check("collide_snd", longint'($signed(snd)), 100);
`ifdef JT12_MIX_READBACK_EN
        rd(15, v); check("drop_set", v, 4);
`endif
        wr(15, 4);

        // Gain write while accumulating: a MAC on the write edge sees the old gain.
        set_ch(100, 100, 100, 100);
        strobe(); tick(); wr(1, 0);
        wait_pulse(n);
        check("gainwr_old", longint'($signed(snd)), 400);
        wr(1, 8'h10);
        strobe(); tick(); wr(3, 0);
        wait_pulse(n);
        check("gainwr_new", longint'($signed(snd)), 300);
        wr(3, 8'h10);

        // cen active 1 cycle in 3 stretches the latency to 15 clocks.
        cen_mode = 1;
        repeat (3) tick();
        set_ch(1000, 2000, -500, 0);
        strobe(); wait_pulse(n);
        check("cen_latency", n, 15);
        check("cen_snd", longint'($signed(snd)), 2500);
        cen_mode = 0;
        repeat (2) tick();

        // Mute forces zero but still strobes.
        wr(15, 1);
        set_ch(1000, 1000, 1000, 1000);
        strobe(); wait_pulse(n);
        check("mute_latency", n, 5);
        check("mute_snd", longint'(snd), 0);
        wr(15, 0);

        // Reset in the middle of accumulation.
        wr(1, 8'h30);
        set_ch(111, 222, 333, 444);
        strobe(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", longint'(busy), 0);
        check("midrst_snd", longint'(snd), 0);
        tick();
        rst_n = 1'b1;
        tick();
`ifdef JT12_MIX_READBACK_EN
        rd(1, v); check("midrst_gain1", v, 16);
`endif
        set_ch(1000, 2000, -500, 0);
        strobe(); wait_pulse(n);
        check("post_rst_snd", longint'($signed(snd)), 2500);
        tick();

        // Randomized traffic: strobes (incl. collisions), bus writes/reads, random cen.
        cen_mode = 2;
        for (int c = 0; c < 4000; c++) begin
            int op;
            in_sample = ($urandom % 10) == 0;
            if ($urandom % 4 == 0) begin
                for (int i = 0; i < NCH; i++) begin
                    case ($urandom % 4)
                        0:       ch_in[i*W +: W] = 16'h7FFF;
                        1:       ch_in[i*W +: W] = 16'h8000;
                        default: ch_in[i*W +: W] = W'($urandom);
                    endcase
                end
            end
            cs_n = 1'b1; wr_n = 1'b1;
            op = int'($urandom % 8);
            case (op)
                0: begin
                    cs_n = 0; wr_n = 0; addr = 4'($urandom % NCH);
                    din = ($urandom % 2) ? 8'($urandom) : 8'($urandom % 32);
                end
                1: begin
                    cs_n = 0; wr_n = 0; addr = 4'hF;
                    din = {5'd0, 1'($urandom), 1'($urandom), ($urandom % 8) == 0};
                end
                2, 3: begin
                    cs_n = 0; wr_n = 1; addr = 4'($urandom);
                end
                4: begin
                    cs_n = 0; wr_n = 0; addr = 4'(NCH + $urandom % (15 - NCH));
                    din = 8'($urandom);
                end
                default: ;
            endcase
            tick();
        end
        in_sample = 1'b0; cs_n = 1'b1; wr_n = 1'b1;
        cen_mode = 0;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
